// File: rtl/cdc_rdptr_empty_fwft_if.sv
// Read-side bus of an async FIFO: synchronized write pointer in, memory read port,
// read pointer/status out, and the first-word-fall-through output stream.
interface cdc_rdptr_empty_fwft_if #(
    parameter int ADDRSIZE = 4,
    parameter int WIDTH    = 32
);
    logic [ADDRSIZE:0]   rdq2_wrptr;
    logic [WIDTH-1:0]    rd_mem_data;
    logic [ADDRSIZE-1:0] rd_addr;
    logic [ADDRSIZE:0]   rd_ptr;
    logic                rd_empty;
    logic [ADDRSIZE:0]   rd_level;
    logic                rd_almost_empty;
    logic [WIDTH-1:0]    dout;
    logic                dout_valid;
    logic                dout_ready;

    // master: the read-pointer/output-stage block
    modport master (
        input  rdq2_wrptr, rd_mem_data, dout_ready,
        output rd_addr, rd_ptr, rd_empty, rd_level, rd_almost_empty, dout, dout_valid
    );

    // slave: memory, write-domain synchronizer and the downstream consumer
    modport slave (
        output rdq2_wrptr, rd_mem_data, dout_ready,
        input  rd_addr, rd_ptr, rd_empty, rd_level, rd_almost_empty, dout, dout_valid
    );
endinterface

// File: rtl/cdc_rdptr_empty_fwft.sv
// Async FIFO read-domain controller: Gray read pointer, registered empty/level/
// almost-empty status and a one-word first-word-fall-through output register.
module cdc_rdptr_empty_fwft #(
    parameter int ADDRSIZE  = 4,
    parameter int WIDTH     = 32,
    parameter int AE_THRESH = 1
) (
    input  logic                          rd_clk,
    input  logic                          rd_rst,
    cdc_rdptr_empty_fwft_if.master        bus
);
    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0]    rbin_reg;
    logic [PW-1:0]    rbin_next;
    logic [PW-1:0]    rgray_reg;
    logic [PW-1:0]    rgray_next;
    logic [PW-1:0]    wbin_sync;
    logic [PW-1:0]    level_next;
    logic             ae_next;
    logic             empty_next;
    logic             rd_empty_reg;
    logic [PW-1:0]    rd_level_reg;
    logic             rd_almost_empty_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             dout_valid_reg;
    logic             pop;

    // Gray-to-binary of the synchronized write pointer: bit i is the XOR of bits MSB..i
    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_gray2bin
            assign wbin_sync[gi] = ^bus.rdq2_wrptr[ADDRSIZE:gi];
        end
    endgenerate

    // Fetch a word whenever memory has one and the output stage is free or being drained
    assign pop        = ~rd_empty_reg & (~dout_valid_reg | bus.dout_ready);
    assign rbin_next  = rbin_reg + {{ADDRSIZE{1'b0}}, pop};
    assign rgray_next = (rbin_next >> 1) ^ rbin_next;
    assign empty_next = (rgray_next == bus.rdq2_wrptr);
    assign level_next = wbin_sync - rbin_next;
    assign ae_next    = (level_next <= PW'(AE_THRESH));

    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            rbin_reg            <= '0;
            rgray_reg           <= '0;
            rd_empty_reg        <= 1'b1;
            rd_level_reg        <= '0;
            rd_almost_empty_reg <= 1'b1;
        end else begin
            rbin_reg            <= rbin_next;
            rgray_reg           <= rgray_next;
            rd_empty_reg        <= empty_next;
            rd_level_reg        <= level_next;
            rd_almost_empty_reg <= ae_next;
        end
    end

    // Output stage: a pop refills it (even while being consumed); a consume without pop drains it
    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
        end else if (pop) begin
            dout_reg       <= bus.rd_mem_data;
            dout_valid_reg <= 1'b1;
        end else if (bus.dout_ready) begin
            dout_valid_reg <= 1'b0;
        end
    end

    assign bus.rd_addr         = rbin_reg[ADDRSIZE-1:0];
    assign bus.rd_ptr          = rgray_reg;
    assign bus.rd_empty        = rd_empty_reg;
    assign bus.rd_level        = rd_level_reg;
    assign bus.rd_almost_empty = rd_almost_empty_reg;
    assign bus.dout            = dout_reg;
    assign bus.dout_valid      = dout_valid_reg;
endmodule

// File: doc/cdc_rdptr_empty_fwft.md
CDC_RDPTR_EMPTY_FWFT -- requirements
Module: cdc_rdptr_empty_fwft

Interface
REQ-001 ADDRSIZE, 4, memory address width; depth = 2^ADDRSIZE.
REQ-002 WIDTH, 32, data word width.
REQ-003 AE_THRESH, 1, rd_almost_empty asserts when rd_level <= AE_THRESH.
REQ-004 rd_clk  input  1  read-domain clock; sole clock, all state on rising edge.
REQ-005 rd_rst  input  1  asynchronous, active-low reset.
REQ-006 rdq2_wrptr  input  ADDRSIZE+1  Gray write pointer, already two-flop synchronized into rd_clk.
REQ-007 rd_mem_data  input  WIDTH  memory read data for rd_addr, combinational (same-cycle) read.
REQ-008 rd_addr  output  ADDRSIZE  memory read address.
REQ-009 rd_ptr  output  ADDRSIZE+1  registered Gray read pointer, for synchronization into write domain.
REQ-010 rd_empty  output  1  registered; memory holds no unread entry (output stage excluded).
REQ-011 rd_level  output  ADDRSIZE+1  registered; entries in memory, output stage excluded.
REQ-012 rd_almost_empty  output  1  registered low-watermark flag.
REQ-013 dout  output  WIDTH  first-word-fall-through output data.
REQ-014 dout_valid  output  1  dout holds a valid word.
REQ-015 dout_ready  input  1  consumer accepts dout this cycle when dout_valid=1.

Function
REQ-016 Internal binary counter rbin (ADDRSIZE+1 bits); rd_addr = rbin[ADDRSIZE-1:0].
REQ-017 pop = ~rd_empty & (~dout_valid | dout_ready); rbinnext = rbin + pop, modulo 2^(ADDRSIZE+1).
REQ-018 rgraynext = (rbinnext >> 1) ^ rbinnext; each edge: rbin <= rbinnext, rd_ptr <= rgraynext.
REQ-019 rd_empty <= (rgraynext == rdq2_wrptr); a rdq2_wrptr change at edge k clears rd_empty at edge k+1.
REQ-020 On pop: dout <= rd_mem_data, dout_valid <= 1 (one-cycle memory-to-dout latency).
REQ-021 No pop, dout_valid=1, dout_ready=1: dout_valid <= 0; dout holds its value.
REQ-022 dout_valid=1, dout_ready=0: dout and dout_valid unchanged; no pop occurs.
REQ-023 dout_ready while dout_valid=0: ignored.
REQ-024 Pop and consume in the same cycle: dout replaced by new word, dout_valid stays 1 (full throughput, one word per cycle).
REQ-025 wbin_sync = Gray-to-binary of rdq2_wrptr (bit i = XOR of Gray bits ADDRSIZE..i).
REQ-026 rd_level <= (wbin_sync - rbinnext) mod 2^(ADDRSIZE+1); range 0..2^ADDRSIZE.
REQ-027 rd_almost_empty <= (that same next-level value) <= AE_THRESH.
REQ-028 Pointer wrap: rbin 2^(ADDRSIZE+1)-1 -> 0 with no special case; rd_addr wraps to 0.
REQ-029 Never pop while rd_empty=1; rd_ptr never passes the synchronized write pointer.

Reset
REQ-030 rd_rst low immediately (no clock needed) forces rbin=0, rd_ptr=0, rd_empty=1, rd_level=0, rd_almost_empty=1, dout=0, dout_valid=0.
REQ-031 Reset mid-transfer discards the dout word; no pop is issued in the release cycle.
REQ-032 Operation resumes on the first rd_clk edge after rd_rst rises.

Verification (ADDRSIZE=4, WIDTH=32, AE_THRESH=1)
REQ-033 Reset: rd_rst=0 -> rd_ptr=0, rd_addr=0, rd_empty=1, dout_valid=0, rd_level=0, rd_almost_empty=1.
REQ-034 Single word: rdq2_wrptr 00000 -> 00001, rd_mem_data=0xA5A5A5A5, dout_ready=0.
  - +1 edge: rd_empty=0.
  - +2 edge: dout=0xA5A5A5A5, dout_valid=1, rd_ptr=00001, rd_empty=1.
REQ-035 Backpressure: 3 words written, dout_ready=0 -> exactly one pop; rd_addr stays 1, rd_level=2, dout stable; dout_ready=1 -> one word per cycle.
REQ-036 Full: rdq2_wrptr=11000 (bin 16), rd_ptr=0 -> rd_level=16; dout_ready=1 held -> 16 consecutive pops, rd_level 16..0, rd_almost_empty asserts at level 1.
REQ-037 Wrap: rbin 31 -> 0 -> rd_ptr 10000 -> 00000, rd_addr 15 -> 0, data order preserved.
REQ-038 Async reset asserted mid-stream between clock edges -> all REQ-030 values appear before the next rd_clk edge.
